// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the two-port memory arbiter: FSM state encoding,
//   requester port ids, default bus widths and small request-decode helpers.
//   No ports (package).
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  function automatic logic port_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

  // A port raising both strobes gets a write; the read strobe is ignored.
  function automatic mem_op_e decode_op(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// rr_arbiter_2
//   Combinational two-requester round-robin grant. Kept standalone so other
//   shared resources can reuse it.
// Ports:
//   req0, req1   in   request from requester 0 / 1
//   last_served  in   id of the requester served most recently
//   grant        out  id of the requester to serve next (0 when idle)
module rr_arbiter_2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic grant
);

  always_comb begin
    grant = PORT_ICACHE;
    if (req0 && req1) begin
      grant = ~last_served;
    end else if (req1) begin
      grant = PORT_DCACHE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one block-addressed memory between the icache (port 0) and the
//   dcache (port 1). Transfers are serialised, contention is resolved
//   round-robin and each requester is stalled on its own busywait until its
//   transfer has completed.
// Ports:
//   clock, reset                 clock; async active-low reset
//   pN_read, pN_write            port N request strobes
//   pN_address, pN_writedata     port N block address / write-back block
//   pN_readdata, pN_busywait     port N returned block / stall
//   mem_read, mem_write          memory strobes (registered)
//   mem_address, mem_writedata   memory address / write block (registered)
//   mem_readdata, mem_busywait   memory read block / busy
//
// state | meaning
// IDLE  | no transfer; pick a requester and latch its request
// ISSUE | first strobe cycle; memory busywait not yet meaningful
// WAIT  | strobe held until memory busywait is sampled low
// DONE  | strobes low; granted port released for this one cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_busywait,

  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_busywait,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  logic [1:0]        state;
  logic              grant;
  logic              grant_q;
  logic              last_served;
  mem_op_e           op_q;

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  mem_op_e           sel_op;
  logic              xfer_end;

  assign req0 = port_req(p0_read, p0_write);
  assign req1 = port_req(p1_read, p1_write);

  rr_arbiter_2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_served),
    .grant       (grant)
  );

  always_comb begin
    sel_address   = p0_address;
    sel_writedata = p0_writedata;
    sel_op        = decode_op(p0_write);
    if (grant == PORT_DCACHE) begin
      sel_address   = p1_address;
      sel_writedata = p1_writedata;
      sel_op        = decode_op(p1_write);
    end
  end

  // Memory busywait is ignored in ISSUE; the first sample that counts is in WAIT.
  assign xfer_end = (state == ST_WAIT) && !mem_busywait;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      grant_q       <= PORT_ICACHE;
      last_served   <= PORT_DCACHE;
      op_q          <= OP_READ;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state         <= ST_ISSUE;
            grant_q       <= grant;
            op_q          <= sel_op;
            mem_address   <= sel_address;
            mem_writedata <= sel_writedata;
            mem_read      <= (sel_op == OP_READ);
            mem_write     <= (sel_op == OP_WRITE);
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (xfer_end) begin
            state       <= ST_DONE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            last_served <= grant_q;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read results land even if the requester has already dropped its request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p0_readdata <= '0;
      p1_readdata <= '0;
    end else if (xfer_end && (op_q == OP_READ)) begin
      if (grant_q == PORT_ICACHE) begin
        p0_readdata <= mem_readdata;
      end else begin
        p1_readdata <= mem_readdata;
      end
    end
  end

  // Combinational in the requests so a fresh request stalls immediately.
  assign p0_busywait = req0 & ~((state == ST_DONE) && (grant_q == PORT_ICACHE));
  assign p1_busywait = req1 & ~((state == ST_DONE) && (grant_q == PORT_DCACHE));

endmodule
